kl8e_tto: RTL and testbench
===========================

KL8E_TTO -- requirements
Module: kl8e_tto

Interface
REQ-001 Parameter CLK_DIV, default 434, meaning clk cycles per serial bit period (legal range 2..4095).
REQ-002 Parameter DEV_CODE, default 6'o04, meaning IOT device select code answered by this block.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 iot  input  1  one-cycle strobe from the CPU while it executes an IOT instruction.
REQ-006 io_select  input  6  IOT device field, instruction bits 3..8.
REQ-007 io_op  input  3  IOT operation bits, instruction bits 9..11.
REQ-008 io_data_in  input  12  CPU AC contents during iot.
REQ-009 io_selected  output  1  high when iot=1 and io_select==DEV_CODE.
REQ-010 io_skip  output  1  skip request, valid in the same cycle as the iot strobe.
REQ-011 io_interrupt  output  1  interrupt request, equal to flag AND ie.
REQ-012 tx  output  1  serial line, idle high, 8N1 framing.
REQ-013 overrun  output  1  sticky, set when a pending character is overwritten.

Function
REQ-014 Decode io_op only when io_selected=1; otherwise have no effect.
REQ-015 io_op 3'o0 (TFL) sets flag.
REQ-016 io_op bit0 (TSF) drives io_skip = flag combinationally; io_skip=0 in all other cases.
REQ-017 io_op 3'o5 (TSK) drives io_skip = io_interrupt instead of TSF behaviour.
REQ-018 io_op bit1 (TCF) clears flag.
REQ-019 io_op bit2 (TPC) loads io_data_in[7:0] for transmission; 6046 = TCF+TPC (TLS).
REQ-020 A load when idle starts the serial frame on the next cycle.
REQ-021 A load when busy with the holding register empty stores the character in the holding register.
REQ-022 A load when busy with the holding register full overwrites it and sets overrun.
REQ-023 Transmitter states: IDLE, START, DATA, STOP.
REQ-024 IDLE, load -> START, with tx=0 for CLK_DIV cycles.
REQ-025 START -> DATA, sending 8 bits LSB first, CLK_DIV cycles each, with a 3-bit bit counter.
REQ-026 DATA -> STOP after bit 7, with tx=1 for CLK_DIV cycles.
REQ-027 STOP end: set flag; go to START if the holding register is full (and empty it), else go to IDLE.
REQ-028 Baud counter: 12 bits, reloads to CLK_DIV-1 on every state entry, counts down to 0; wrap-around never occurs.
REQ-029 Flag set (STOP end or TFL) and TCF in the same cycle: set wins.
REQ-030 Frame duration is 10*CLK_DIV cycles from the first tx=0 to the flag set.
REQ-031 io_op bit combination 3'o5 with ie: ie is set by KIE-style op only via DEV_CODE+1 not decoded here; ie resets to 1 and is otherwise constant.

Reset
REQ-032 reset forces state=IDLE, tx=1, flag=0, holding register empty, overrun=0, ie=1, baud counter=0, bit counter=0.
REQ-033 reset mid-frame aborts the character immediately: tx=1 on the next cycle, no flag set.
REQ-034 Outputs after reset: io_skip=0, io_interrupt=0, io_selected follows its inputs.

Structure
REQ-035 The shared pdp8 definitions include holds the IOT op encodings (TFL/TSF/TCF/TPC), the default DEV_CODE and the transmitter state encodings.
REQ-036 The serial shifter and baud counter are a sub-module uart_tx (ports: clk, reset, start, data[7:0], busy, done, tx); kl8e_tto holds the IOT decode, flag, ie, holding register and overrun.

Verification (CLK_DIV=4)
REQ-037 IOT 6046 with AC=0215 -> tx shows 0 for 4 cycles, then 1,0,1,1,0,0,0,1 at 4 cycles each, then 1 for 4 cycles; flag=1 exactly 40 cycles after the first tx=0.
REQ-038 6041 before frame end -> io_skip=0; 6041 after frame end -> io_skip=1; 6042, then 6041 -> io_skip=0.
REQ-039 Three 6044 loads (0101, 0102, 0103) back to back -> 0101 then 0103 transmitted with no idle gap, overrun=1.
REQ-040 6042 in the exact cycle the STOP period ends -> flag=1 afterwards.
REQ-041 reset at DATA bit 3 -> tx=1 next cycle, flag=0, state IDLE; a following 6046 with AC=0212 -> clean 0x8A frame.
REQ-042 iot with io_select=6'o03 and io_op=3'o6 -> no tx activity, io_skip=0, flag unchanged.

Source files
------------

// File: rtl/kl8e_tto_pkg.sv
// KL8E teleprinter output shared definitions:
// IOT op encodings, default device code, transmitter states.
package kl8e_tto_pkg;

  localparam logic [5:0] TTO_DEV_CODE = 6'o04;

  localparam logic [2:0] OP_TFL = 3'o0;
  localparam logic [2:0] OP_TSK = 3'o5;

  localparam int unsigned OP_TSF = 0;
  localparam int unsigned OP_TCF = 1;
  localparam int unsigned OP_TPC = 2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/kl8e_tto_uart_tx.sv
// 8N1 serial shifter with baud counter.
// done pulses in the last cycle of the stop bit.
import kl8e_tto_pkg::*;

module uart_tx #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam logic [11:0] RELOAD = 12'(CLK_DIV - 1);

  tx_state_e   state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        tick;

  assign tick = (cnt_q == 12'd0);
  assign busy = (state_q != TX_IDLE);
  assign done = (state_q == TX_STOP) && tick;
  assign tx   = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      TX_IDLE: begin
        if (start) begin
          state_d = TX_START;
          cnt_d   = RELOAD;
          bit_d   = 3'd0;
          shift_d = data;
        end
      end
      TX_START: begin
        if (tick) begin
          state_d = TX_DATA;
          cnt_d   = RELOAD;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      TX_DATA: begin
        if (tick) begin
          cnt_d = RELOAD;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      TX_STOP: begin
        if (tick) begin
          // a queued character follows with no idle gap
          if (start) begin
            state_d = TX_START;
            cnt_d   = RELOAD;
            bit_d   = 3'd0;
            shift_d = data;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
    if (state_d == TX_DATA) begin
      tx_d = shift_d[0];
    end else begin
      tx_d = (state_d != TX_START);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/kl8e_tto.sv
// KL8E teleprinter output: IOT decode, flag, interrupt
// enable, one-character holding register and overrun.
import kl8e_tto_pkg::*;

module kl8e_tto #(
  parameter int unsigned CLK_DIV  = 434,
  parameter logic [5:0]  DEV_CODE = TTO_DEV_CODE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iot,
  input  logic [5:0]  io_select,
  input  logic [2:0]  io_op,
  input  logic [11:0] io_data_in,
  output logic        io_selected,
  output logic        io_skip,
  output logic        io_interrupt,
  output logic        tx,
  output logic        overrun
);

  logic       flag_q, flag_d;
  logic       ie_q, ie_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       overrun_q, overrun_d;

  logic       tfl, tcf, tpc;
  logic       start;
  logic [7:0] start_data;
  logic       busy, done;
  logic       unused_ok;

  assign unused_ok = ^io_data_in[11:8];

  assign io_selected  = iot && (io_select == DEV_CODE);
  assign io_interrupt = flag_q && ie_q;
  assign overrun      = overrun_q;

  assign tfl = io_selected && (io_op == OP_TFL);
  assign tcf = io_selected && io_op[OP_TCF];
  assign tpc = io_selected && io_op[OP_TPC];

  always_comb begin
    io_skip = 1'b0;
    if (io_selected) begin
      if (io_op == OP_TSK) begin
        io_skip = io_interrupt;
      end else begin
        io_skip = io_op[OP_TSF] && flag_q;
      end
    end
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    overrun_d   = overrun_q;
    ie_d        = ie_q;
    start       = 1'b0;
    start_data  = io_data_in[7:0];
    // at frame end the held char is drained, so a load
    // arriving then refills the register without overrun
    if (done) begin
      start       = hold_full_q || tpc;
      hold_full_d = hold_full_q && tpc;
      if (hold_full_q) begin
        start_data = hold_q;
        if (tpc) begin
          hold_d = io_data_in[7:0];
        end
      end
    end else if (tpc) begin
      if (!busy) begin
        start = 1'b1;
      end else begin
        hold_d      = io_data_in[7:0];
        hold_full_d = 1'b1;
        if (hold_full_q) begin
          overrun_d = 1'b1;
        end
      end
    end
    if (done || tfl) begin
      flag_d = 1'b1;
    end else if (tcf) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q      <= 1'b0;
      ie_q        <= 1'b1;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      flag_q      <= flag_d;
      ie_q        <= ie_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (start_data),
    .busy  (busy),
    .done  (done),
    .tx    (tx)
  );

endmodule

// File: tb/tb_kl8e_tto.sv
// Directed bench for kl8e_tto with CLK_DIV=4.
module tb_kl8e_tto;

  logic        clk;
  logic        reset;
  logic        iot;
  logic [5:0]  io_select;
  logic [2:0]  io_op;
  logic [11:0] io_data_in;
  logic        io_selected;
  logic        io_skip;
  logic        io_interrupt;
  logic        tx;
  logic        overrun;

  int n_asrt = 0;
  int n_fail = 0;
  logic sk, sl;

  kl8e_tto #(
    .CLK_DIV (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .iot          (iot),
    .io_select    (io_select),
    .io_op        (io_op),
    .io_data_in   (io_data_in),
    .io_selected  (io_selected),
    .io_skip      (io_skip),
    .io_interrupt (io_interrupt),
    .tx           (tx),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one-cycle IOT; skip/selected sampled mid-cycle
  task automatic do_iot(input logic [5:0] s,
                        input logic [2:0] op,
                        input logic [11:0] ac,
                        output logic skip,
                        output logic selected);
    iot        = 1'b1;
    io_select  = s;
    io_op      = op;
    io_data_in = ac;
    #2;
    skip     = io_skip;
    selected = io_selected;
    @(posedge clk);
    #1;
    iot        = 1'b0;
    io_select  = '0;
    io_op      = '0;
    io_data_in = '0;
  endtask

  // expected tx at position pos (0..39) of a frame
  function automatic logic exp_tx(input logic [7:0] ch,
                                  input int pos);
    if (pos < 4) return 1'b0;
    if (pos < 36) return ch[(pos - 4) / 4];
    return 1'b1;
  endfunction

  // sample from position 'from' to 39, flag must stay low
  task automatic check_frame(input string tag,
                             input logic [7:0] ch,
                             input int from);
    for (int p = from; p < 40; p++) begin
      chk($sformatf("%s_tx%0d", tag, p),
          {31'd0, tx}, {31'd0, exp_tx(ch, p)});
      chk($sformatf("%s_irq%0d", tag, p),
          {31'd0, io_interrupt}, 32'd0);
      tick(1);
    end
    chk({tag, "_flag40"}, {31'd0, io_interrupt}, 32'd1);
    chk({tag, "_idle40"}, {31'd0, tx}, 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    iot        = 1'b0;
    io_select  = '0;
    io_op      = '0;
    io_data_in = '0;
    tick(3);
    reset = 1'b0;

    // reset state
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_irq", {31'd0, io_interrupt}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_skip", {31'd0, io_skip}, 32'd0);
    chk("rst_sel_idle", {31'd0, io_selected}, 32'd0);
    do_iot(6'o04, 3'o1, 12'o0, sk, sl);
    chk("rst_sel", {31'd0, sl}, 32'd1);
    chk("rst_tsf", {31'd0, sk}, 32'd0);

    // TLS 0215 waveform and 40-cycle flag latency
    do_iot(6'o04, 3'o6, 12'o0215, sk, sl);
    check_frame("f215", 8'h8D, 0);
    do_iot(6'o04, 3'o1, 12'o0, sk, sl);
    chk("tsf_after", {31'd0, sk}, 32'd1);
    do_iot(6'o04, 3'o2, 12'o0, sk, sl);
    do_iot(6'o04, 3'o1, 12'o0, sk, sl);
    chk("tsf_cleared", {31'd0, sk}, 32'd0);

    // skip before and after frame end
    do_iot(6'o04, 3'o6, 12'o0101, sk, sl);
    do_iot(6'o04, 3'o1, 12'o0, sk, sl);
    chk("tsf_busy", {31'd0, sk}, 32'd0);
    tick(45);
    do_iot(6'o04, 3'o1, 12'o0, sk, sl);
    chk("tsf_done", {31'd0, sk}, 32'd1);
    do_iot(6'o04, 3'o5, 12'o0, sk, sl);
    chk("tsk_irq", {31'd0, sk}, 32'd1);
    tick(45);
    do_iot(6'o04, 3'o2, 12'o0, sk, sl);
    chk("tcf_irq", {31'd0, io_interrupt}, 32'd0);

    // TFL sets flag; foreign device has no effect
    do_iot(6'o04, 3'o0, 12'o0, sk, sl);
    chk("tfl_irq", {31'd0, io_interrupt}, 32'd1);
    do_iot(6'o03, 3'o6, 12'o0377, sk, sl);
    chk("oth_sel", {31'd0, sl}, 32'd0);
    chk("oth_skip", {31'd0, sk}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("oth_tx%0d", i), {31'd0, tx}, 32'd1);
      tick(1);
    end
    chk("oth_flag", {31'd0, io_interrupt}, 32'd1);

    // TCF in the exact cycle the stop bit ends
    do_iot(6'o04, 3'o6, 12'o0125, sk, sl);
    tick(38);
    chk("race_pre_irq", {31'd0, io_interrupt}, 32'd0);
    chk("race_pre_tx", {31'd0, tx}, 32'd1);
    tick(1);
    do_iot(6'o04, 3'o2, 12'o0, sk, sl);
    chk("race_set_wins", {31'd0, io_interrupt}, 32'd1);
    tick(4);

    // three back-to-back loads: 0101, then 0103
    do_iot(6'o04, 3'o4, 12'o0101, sk, sl);
    do_iot(6'o04, 3'o4, 12'o0102, sk, sl);
    do_iot(6'o04, 3'o4, 12'o0103, sk, sl);
    chk("b2b_ovr", {31'd0, overrun}, 32'd1);
    for (int g = 2; g < 80; g++) begin
      chk($sformatf("b2b_tx%0d", g), {31'd0, tx},
          {31'd0, exp_tx((g < 40) ? 8'h41 : 8'h43, g % 40)});
      tick(1);
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_idle%0d", i), {31'd0, tx}, 32'd1);
      tick(1);
    end
    chk("b2b_ovr_sticky", {31'd0, overrun}, 32'd1);

    // reset during data bit 3 aborts the frame
    do_iot(6'o04, 3'o6, 12'o0215, sk, sl);
    tick(17);
    chk("abort_bit3", {31'd0, tx}, 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_irq", {31'd0, io_interrupt}, 32'd0);
    chk("abort_ovr", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 50; i++) begin
      chk($sformatf("abort_q%0d", i),
          {30'd0, tx, io_interrupt}, 32'd2);
      tick(1);
    end
    do_iot(6'o04, 3'o6, 12'o0212, sk, sl);
    check_frame("f212", 8'h8A, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
